tx_symbol_sequencer: RTL

Upstream feeder for the 2-bit symbol mux. Accepts a byte over a valid/ready handshake and emits a framed symbol stream: preamble, four data dibits MSB-first, and an optional parity symbol. It drives the mux select lines `sB`/`sA` and the symbol buses feeding mux inputs `in0` (control path) and `in1` (data path). Each symbol is held for a programmable number of clocks.

---
 rtl/tx_symbol_sequencer_if.sv | 28 ++
 rtl/tx_symbol_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/tx_symbol_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tx_symbol_sequencer_if                                          |
// | Brief    : Byte handshake and symbol-mux drive bundle for the sequencer.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface tx_symbol_sequencer_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       sB;
   logic       sA;
   logic [1:0] sym0;
   logic [1:0] sym1;
   logic       sym_strobe;
   logic       frame_done;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, sB, sA, sym0, sym1, sym_strobe, frame_done
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, sB, sA, sym0, sym1, sym_strobe, frame_done
   );
endinterface
`default_nettype wire

// File: rtl/tx_symbol_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tx_symbol_sequencer                                             |
// | Brief    : Frames a byte as preamble + 4 data dibits (+ parity symbol when |
// |            TX_PARITY_EN is defined) and drives the 2-bit symbol mux.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tx_symbol_sequencer #(
   parameter int PREAMBLE_LEN = 4,
   parameter int SYM_DIV      = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   tx_symbol_sequencer_if.slave    bus
);

   localparam logic [7:0] c_last_tick = 8'(SYM_DIV - 1);
   localparam logic [3:0] c_last_pre  = 4'(PREAMBLE_LEN - 1);
   localparam logic [3:0] c_last_data = 4'd3;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      DATA     = 2'd2
`ifdef TX_PARITY_EN
      ,
      PARITY   = 2'd3
`endif
   } state_t;

   state_t     r_state, w_state;
   logic [7:0] r_tick, w_tick;
   logic [3:0] r_idx, w_idx;
   logic [7:0] r_byte, w_byte;
   logic       w_wrap;

   logic       r_tx_ready, w_tx_ready;
   logic [1:0] r_sel, w_sel;
   logic [1:0] r_sym0, w_sym0;
   logic [1:0] r_sym1, w_sym1;
   logic       r_strobe, w_strobe;
   logic       r_done, w_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_tick     <= 8'd0;
         r_idx      <= 4'd0;
         r_byte     <= 8'd0;
         r_tx_ready <= 1'b0;
         r_sel      <= 2'b10;
         r_sym0     <= 2'b00;
         r_sym1     <= 2'b00;
         r_strobe   <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_tick     <= w_tick;
         r_idx      <= w_idx;
         r_byte     <= w_byte;
         r_tx_ready <= w_tx_ready;
         r_sel      <= w_sel;
         r_sym0     <= w_sym0;
         r_sym1     <= w_sym1;
         r_strobe   <= w_strobe;
         r_done     <= w_done;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_tick     = r_tick;
      w_idx      = r_idx;
      w_byte     = r_byte;
      w_wrap     = (r_tick == c_last_tick);

      case (r_state)
         IDLE: begin
            if (bus.tx_valid && r_tx_ready) begin
               w_state = PREAMBLE;
               w_tick  = 8'd0;
               w_idx   = 4'd0;
               w_byte  = bus.tx_data;
            end
         end
         default: begin
            w_tick = w_wrap ? 8'd0 : r_tick + 8'd1;
            if (w_wrap) begin
               w_idx = r_idx + 4'd1;
               if (r_state == PREAMBLE && r_idx == c_last_pre) begin
                  w_state = DATA;
                  w_idx   = 4'd0;
               end else if (r_state == DATA && r_idx == c_last_data) begin
`ifdef TX_PARITY_EN
                  w_state = PARITY;
`else
                  w_state = IDLE;
`endif
                  w_idx   = 4'd0;
               end
`ifdef TX_PARITY_EN
               else if (r_state == PARITY) begin
                  w_state = IDLE;
                  w_idx   = 4'd0;
               end
`endif
            end
         end
      endcase

      // Outputs are decoded from the next state so they land registered on the
      // same edge as the state change, keeping select and data aligned.
      w_tx_ready = 1'b0;
      w_sel      = 2'b10;
      w_sym0     = 2'b00;
      w_sym1     = 2'b00;
      w_strobe   = (w_state != IDLE) && (w_tick == 8'd0);
      w_done     = 1'b0;

      case (w_state)
         IDLE: w_tx_ready = 1'b1;
         PREAMBLE: begin
            w_sel  = 2'b00;
            w_sym0 = w_idx[0] ? 2'b01 : 2'b10;
         end
         DATA: begin
            w_sel = 2'b01;
            case (w_idx[1:0])
               2'd0:    w_sym1 = w_byte[7:6];
               2'd1:    w_sym1 = w_byte[5:4];
               2'd2:    w_sym1 = w_byte[3:2];
               default: w_sym1 = w_byte[1:0];
            endcase
`ifndef TX_PARITY_EN
            w_done = (w_idx == c_last_data) && (w_tick == c_last_tick);
`endif
         end
`ifdef TX_PARITY_EN
         PARITY: begin
            w_sel  = 2'b00;
            w_sym0 = {1'b1, ^w_byte};
            w_done = (w_tick == c_last_tick);
         end
`endif
         default: ;
      endcase
   end

   assign bus.tx_ready   = r_tx_ready;
   assign bus.sB         = r_sel[1];
   assign bus.sA         = r_sel[0];
   assign bus.sym0       = r_sym0;
   assign bus.sym1       = r_sym1;
   assign bus.sym_strobe = r_strobe;
   assign bus.frame_done = r_done;

endmodule
`default_nettype wire
